ps2_cursor_sequencer: RTL and testbench

- Single-clock controller that receives PS/2 keyboard frames on the pixel/system clock and decodes make/break/extended prefixes.
- Turns arrow and space make-codes into cursor-position and colour commands for the VGA square overlay.
- Commits each command only at the start of vertical sync, so the square never tears mid-frame.
- Sits between the PS/2 pins and the VGA controller's iXRedCounter/iYRedCounter/iColorCuadro inputs.

---
 rtl/ps2_cursor_sequencer_pkg.sv | 27 ++
 rtl/ps2_cursor_sequencer_rx.sv | 100 ++++++++++
 rtl/ps2_cursor_sequencer.sv | 135 +++++++++++++
 tb/tb_ps2_cursor_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_cursor_sequencer_pkg.sv
// Shared scan codes, receiver states and command encoding for the PS/2 cursor sequencer.
package ps2_cursor_sequencer_pkg;

  localparam logic [7:0] SC_IZQ = 8'h6B;
  localparam logic [7:0] SC_DER = 8'h74;
  localparam logic [7:0] SC_ARR = 8'h75;
  localparam logic [7:0] SC_ABA = 8'h72;
  localparam logic [7:0] SC_ESP = 8'h29;
  localparam logic [7:0] SC_BRK = 8'hF0;
  localparam logic [7:0] SC_EXT = 8'hE0;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  typedef enum logic [2:0] {CMD_NONE, CMD_L, CMD_R, CMD_U, CMD_D, CMD_COL} cmd_e;

  function automatic cmd_e scan_to_cmd(input logic [7:0] code);
    case (code)
      SC_IZQ:  return CMD_L;
      SC_DER:  return CMD_R;
      SC_ARR:  return CMD_U;
      SC_ABA:  return CMD_D;
      SC_ESP:  return CMD_COL;
      default: return CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_cursor_sequencer_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, framing/parity check and timeout.
module ps2_rx_frame
  import ps2_cursor_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 5000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [2:0]  clk_sync_q;
  logic [1:0]  data_sync_q;
  rx_state_e   state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        parity_q, parity_d;
  logic [15:0] tmo_q, tmo_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        fall, din;

  assign fall = clk_sync_q[2] & ~clk_sync_q[1];
  assign din  = data_sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      state_q     <= RX_IDLE;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;
    tmo_d    = fall ? '0 : tmo_q + 16'd1;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        tmo_d = '0;
        if (fall && !din) begin
          state_d  = RX_DATA;
          bitcnt_d = '0;
        end
      end
      RX_DATA: if (fall) begin
        shreg_d  = {din, shreg_q[7:1]};
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) state_d = RX_PARITY;
      end
      RX_PARITY: if (fall) begin
        parity_d = din;
        state_d  = RX_STOP;
      end
      RX_STOP: if (fall) begin
        state_d = RX_IDLE;
        if (din && ((^shreg_q) ^ parity_q)) valid_d = 1'b1;
        else                                err_d   = 1'b1;
      end
      default: state_d = RX_IDLE;
    endcase
    // A stalled partial frame is abandoned once the line stays quiet for TIMEOUT cycles.
    if (state_q != RX_IDLE && !fall && tmo_q == TMO_LAST) begin
      state_d = RX_IDLE;
      err_d   = 1'b1;
      tmo_d   = '0;
    end
  end

  assign byte_valid_o = valid_q;
  assign byte_o       = shreg_q;
  assign frame_err_o  = err_q;

endmodule

// File: rtl/ps2_cursor_sequencer.sv
// Decodes PS/2 make codes into cursor/colour commands and commits them on vsync falling edges.
module ps2_cursor_sequencer
  import ps2_cursor_sequencer_pkg::*;
#(
  parameter int         STEP_X     = 96,
  parameter int         STEP_Y     = 32,
  parameter int         X_MAX      = 192,
  parameter int         Y_MAX      = 32,
  parameter int         TIMEOUT    = 5000,
  parameter logic [2:0] COLOR_INIT = 3'b001
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iPS2_CLK,
  input  logic       iPS2_DATA,
  input  logic       iVsync,
  output logic [9:0] oXRedCounter,
  output logic [9:0] oYRedCounter,
  output logic [2:0] oColorCuadro,
  output logic       oKeyValid,
  output logic       oFrameError,
  output logic       oOverrun
);

  localparam logic [10:0] SX = 11'(STEP_X);
  localparam logic [10:0] SY = 11'(STEP_Y);
  localparam logic [10:0] XM = 11'(X_MAX);
  localparam logic [10:0] YM = 11'(Y_MAX);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [2:0] vs_sync_q;
  logic       ext_q, ext_d, brk_q, brk_d;
  logic       pend_full_q, pend_full_d;
  cmd_e       pend_cmd_q, pend_cmd_d, cmd_in;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [2:0] col_q, col_d;
  logic       kv_q, kv_d, ov_q, ov_d;
  logic       commit;
  logic [10:0] x_w, y_w, x_sum, y_sum;

  ps2_rx_frame #(.TIMEOUT(TIMEOUT)) u_rx (
    .clk_i        (Clock),
    .rst_ni       (Reset),
    .ps2_clk_i    (iPS2_CLK),
    .ps2_data_i   (iPS2_DATA),
    .byte_valid_o (rx_valid),
    .byte_o       (rx_byte),
    .frame_err_o  (oFrameError)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      vs_sync_q   <= '1;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      pend_full_q <= 1'b0;
      pend_cmd_q  <= CMD_NONE;
      x_q         <= '0;
      y_q         <= '0;
      col_q       <= COLOR_INIT;
      kv_q        <= 1'b0;
      ov_q        <= 1'b0;
    end else begin
      vs_sync_q   <= {vs_sync_q[1:0], iVsync};
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      pend_full_q <= pend_full_d;
      pend_cmd_q  <= pend_cmd_d;
      x_q         <= x_d;
      y_q         <= y_d;
      col_q       <= col_d;
      kv_q        <= kv_d;
      ov_q        <= ov_d;
    end
  end

  assign commit = vs_sync_q[2] & ~vs_sync_q[1] & pend_full_q;
  assign x_w    = {1'b0, x_q};
  assign y_w    = {1'b0, y_q};
  assign x_sum  = x_w + SX;
  assign y_sum  = y_w + SY;

  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    pend_full_d = pend_full_q;
    pend_cmd_d  = pend_cmd_q;
    x_d         = x_q;
    y_d         = y_q;
    col_d       = col_q;
    kv_d        = 1'b0;
    ov_d        = 1'b0;
    cmd_in      = CMD_NONE;

    if (commit) begin
      pend_full_d = 1'b0;
      case (pend_cmd_q)
        CMD_L:   x_d = (x_w < SX) ? '0 : 10'(x_w - SX);
        CMD_R:   x_d = (x_sum > XM) ? XM[9:0] : x_sum[9:0];
        CMD_U:   y_d = (y_w < SY) ? '0 : 10'(y_w - SY);
        CMD_D:   y_d = (y_sum > YM) ? YM[9:0] : y_sum[9:0];
        CMD_COL: col_d = col_q + 3'd1;
        default: ;
      endcase
    end

    if (rx_valid) begin
      case (rx_byte)
        SC_EXT: ext_d = 1'b1;
        SC_BRK: brk_d = 1'b1;
        default: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          if (!brk_q) cmd_in = scan_to_cmd(rx_byte);
        end
      endcase
    end

    // A write landing in the commit cycle refills the slot just emptied, so it is not an overrun.
    if (cmd_in != CMD_NONE) begin
      kv_d        = 1'b1;
      ov_d        = pend_full_q & ~commit;
      pend_full_d = 1'b1;
      pend_cmd_d  = cmd_in;
    end
  end

  assign oXRedCounter = x_q;
  assign oYRedCounter = y_q;
  assign oColorCuadro = col_q;
  assign oKeyValid    = kv_q;
  assign oOverrun     = ov_q;

endmodule

// File: tb/tb_ps2_cursor_sequencer.sv
// Randomized and directed bench for ps2_cursor_sequencer against a behavioural cursor model.
module tb_ps2_cursor_sequencer;

  localparam int HALF = 10;

  logic       Clock = 1'b0;
  logic       Reset, iPS2_CLK, iPS2_DATA, iVsync;
  logic [9:0] oXRedCounter, oYRedCounter;
  logic [2:0] oColorCuadro;
  logic       oKeyValid, oFrameError, oOverrun;

  always #5 Clock = ~Clock;

  ps2_cursor_sequencer #(
    .STEP_X(96), .STEP_Y(32), .X_MAX(192), .Y_MAX(32), .TIMEOUT(5000), .COLOR_INIT(3'b001)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iPS2_CLK     (iPS2_CLK),
    .iPS2_DATA    (iPS2_DATA),
    .iVsync       (iVsync),
    .oXRedCounter (oXRedCounter),
    .oYRedCounter (oYRedCounter),
    .oColorCuadro (oColorCuadro),
    .oKeyValid    (oKeyValid),
    .oFrameError  (oFrameError),
    .oOverrun     (oOverrun)
  );

  int kv_cnt = 0, fe_cnt = 0, ov_cnt = 0;
  always @(negedge Clock) begin
    if (oKeyValid)   kv_cnt++;
    if (oFrameError) fe_cnt++;
    if (oOverrun)    ov_cnt++;
  end

  int n_chk = 0, n_err = 0;
  int mx, my, mcol, e_kv = 0, e_fe = 0, e_ov = 0;
  bit m_ext, m_brk, m_pend;
  logic [7:0] m_pcode;
  int lat;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit is_cmd(input logic [7:0] b);
    return b == 8'h6B || b == 8'h74 || b == 8'h75 || b == 8'h72 || b == 8'h29;
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mcol = 1; m_ext = 0; m_brk = 0; m_pend = 0; m_pcode = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (!m_brk && is_cmd(b)) begin
        e_kv++;
        if (m_pend) e_ov++;
        m_pend = 1;
        m_pcode = b;
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic model_vsync();
    if (m_pend) begin
      case (m_pcode)
        8'h6B: mx = (mx < 96) ? 0 : mx - 96;
        8'h74: mx = (mx + 96 > 192) ? 192 : mx + 96;
        8'h75: my = (my < 32) ? 0 : my - 32;
        8'h72: my = (my + 32 > 32) ? 32 : my + 32;
        default: mcol = (mcol + 1) % 8;
      endcase
      m_pend = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".x"},   int'(oXRedCounter), mx);
    check({tag, ".y"},   int'(oYRedCounter), my);
    check({tag, ".col"}, int'(oColorCuadro), mcol);
    check({tag, ".kv"},  kv_cnt, e_kv);
    check({tag, ".fe"},  fe_cnt, e_fe);
    check({tag, ".ov"},  ov_cnt, e_ov);
  endtask

  task automatic ps2_bit(input logic v);
    iPS2_DATA = v;
    repeat (HALF) @(negedge Clock);
    iPS2_CLK = 1'b0;
    repeat (HALF) @(negedge Clock);
    iPS2_CLK = 1'b1;
  endtask

  // Drives one full frame; optionally drops vsync one cycle after the stop-bit edge.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit vs_at_stop);
    logic [10:0] bits;
    int k0;
    bits = {~bad_stop, (~(^b)) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
    iPS2_DATA = bits[10];
    repeat (HALF) @(negedge Clock);
    iPS2_CLK = 1'b0;
    k0 = kv_cnt;
    lat = 0;
    for (int k = 1; k <= HALF; k++) begin
      @(negedge Clock);
      if (k == 1 && vs_at_stop) iVsync = 1'b0;
      if (lat == 0 && kv_cnt != k0) lat = k;
    end
    iPS2_CLK = 1'b1;
    iPS2_DATA = 1'b1;
    repeat (10) @(negedge Clock);
    iVsync = 1'b1;
    repeat (4) @(negedge Clock);
    if (vs_at_stop) model_vsync();
    if (bad_par || bad_stop) e_fe++;
    else model_byte(b);
  endtask

  task automatic vsync_pulse();
    iVsync = 1'b0;
    repeat (6) @(negedge Clock);
    iVsync = 1'b1;
    repeat (4) @(negedge Clock);
    model_vsync();
  endtask

  task automatic key(input logic [7:0] b);
    send_frame(b, 0, 0, 0);
  endtask

  initial begin
    logic [7:0] pool [8];
    logic [7:0] b;
    int r;
    pool = '{8'h6B, 8'h74, 8'h75, 8'h72, 8'h29, 8'hE0, 8'hF0, 8'h1C};
    Reset = 1'b0; iPS2_CLK = 1'b1; iPS2_DATA = 1'b1; iVsync = 1'b1;
    model_reset();
    repeat (3) @(negedge Clock);
    check_all("reset");
    Reset = 1'b1;
    repeat (10000) @(negedge Clock);
    check_all("idle");

    key(8'h74);
    check("kv_latency", int'(lat >= 1 && lat <= 5), 1);
    check_all("right_pending");
    vsync_pulse(); check_all("right1");
    key(8'h74); vsync_pulse(); check_all("right2");
    key(8'h74); vsync_pulse(); check_all("right_clamp");

    key(8'h6B); vsync_pulse(); check_all("left_to96");
    key(8'hE0); key(8'h6B); key(8'hF0); key(8'hE0); key(8'h6B);
    check_all("ext_and_release");
    vsync_pulse(); check_all("left_to0");
    key(8'h6B); vsync_pulse(); check_all("left_clamp");

    send_frame(8'h29, 1, 0, 0); check_all("bad_parity");
    send_frame(8'h29, 0, 1, 0); check_all("bad_stop");
    while (mcol != 7) begin key(8'h29); vsync_pulse(); end
    for (int i = 0; i < 5; i++) begin key(8'h29); vsync_pulse(); check_all("color_wrap"); end

    for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
    repeat (6000) @(negedge Clock);
    e_fe++;
    check_all("timeout");
    key(8'h75); vsync_pulse(); check_all("after_timeout");

    key(8'h72); key(8'h29); check_all("overrun");
    vsync_pulse(); check_all("overrun_commit");

    key(8'h74);
    send_frame(8'h29, 0, 0, 1); check_all("commit_collide");
    vsync_pulse(); check_all("collide_next");

    key(8'hF0);
    for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    model_reset();
    check_all("reset_midframe");
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    repeat (5) @(negedge Clock);
    key(8'h74); check_all("post_reset_key");
    vsync_pulse(); check_all("post_reset_commit");

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      b = pool[$urandom_range(0, 7)];
      if (b == 8'h1C) b = 8'($urandom);
      if (r <= 5)      key(b);
      else if (r == 6) send_frame(b, 1, 0, 0);
      else if (r == 7) send_frame(b, 0, 1, 0);
      else             vsync_pulse();
      check_all("random");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
